fdivsqrt_iter: RTL and testbench

Iterative mantissa core for FP32 division and square root. It is the iteration stage between the div/sqrt pre-processing stage, which unpacks operands, normalises subnormals, and computes `virtual_expo` and the special-case flags, and the post-processing stage, which normalises, rounds, and packs using `quo`/`rem`. It accepts one normalised mantissa operation at a time and produces the raw quotient/root and the exact remainder after a fixed number of cycles. Special cases (NaN, Inf, zero) are resolved outside this block.

---
 rtl/fdivsqrt_iter.sv | 146 ++++++++++++++
 tb/tb_fdivsqrt_iter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fdivsqrt_iter.sv
// Iterative FP32 mantissa divide / square-root core (restoring, k bits per cycle; FDIVSQRT_RADIX4_EN selects k=2).
// Latency: start accepted in T, done pulse in T+N+1 (N=26, or 13 with FDIVSQRT_RADIX4_EN).
// Backpressure: start is honoured only while ready=1; no queueing, and flush aborts without a done pulse.
module fdivsqrt_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic        is_divide,
  input  logic [23:0] lhs_mant,
  input  logic [23:0] rhs_mant,
  input  logic        sqrt_shift,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [25:0] quo,
  output logic [26:0] rem
);

`ifdef FDIVSQRT_RADIX4_EN
  localparam int       STEPS  = 2;
  localparam logic [4:0] N_ITER = 5'd13;
`else
  localparam int       STEPS  = 1;
  localparam logic [4:0] N_ITER = 5'd26;
`endif

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  // r: working remainder as consumed by the next step; rn: true remainder after a step
  typedef struct packed {
    logic [28:0] r;
    logic [26:0] rn;
    logic [25:0] q;
    logic [51:0] m;
  } step_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        div_q;
  logic [23:0] b_q;
  logic [28:0] r_q;
  logic [25:0] q_q;
  logic [51:0] m_q;
  logic [24:0] rad;
  step_t       stg [STEPS+1];

  function automatic step_t do_step(input logic div, input logic [23:0] b, input step_t s);
    step_t       o;
    logic [28:0] rt;
    logic [28:0] t;
    logic [28:0] d;
    logic        bit_q;
    o = s;
    if (div) begin
      rt = s.r;
      t  = {5'd0, b};
    end else begin
      // Bring down the next radicand bit pair and try 4q+1
      rt = {s.r[26:0], s.m[51:50]};
      t  = {1'b0, s.q, 2'b01};
    end
    bit_q = (rt >= t);
    d     = bit_q ? (rt - t) : rt;
    o.rn  = d[26:0];
    o.r   = div ? {d[27:0], 1'b0} : d;
    o.m   = div ? s.m : {s.m[49:0], 2'b00};
    o.q   = {s.q[24:0], bit_q};
    return o;
  endfunction

  always_comb begin
    stg[0] = '{r: r_q, rn: '0, q: q_q, m: m_q};
    for (int i = 0; i < STEPS; i++) begin
      stg[i+1] = do_step(div_q, b_q, stg[i]);
    end
  end

  assign rad = sqrt_shift ? {lhs_mant, 1'b0} : {1'b0, lhs_mant};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      quo   <= '0;
      rem   <= '0;
      cnt   <= '0;
      div_q <= 1'b0;
      b_q   <= '0;
      r_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
    end else if (flush) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= ITER;
            ready <= 1'b0;
            busy  <= 1'b1;
            done  <= 1'b0;
            cnt   <= N_ITER;
            div_q <= is_divide;
            b_q   <= rhs_mant;
            q_q   <= '0;
            r_q   <= is_divide ? {5'd0, lhs_mant} : '0;
            m_q   <= is_divide ? '0 : {rad, 27'd0};
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        ITER: begin
          r_q <= stg[STEPS].r;
          q_q <= stg[STEPS].q;
          m_q <= stg[STEPS].m;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state <= DONE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            quo   <= stg[STEPS].q;
            rem   <= stg[STEPS].rn;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fdivsqrt_iter.sv
// Scoreboarded bench for fdivsqrt_iter: directed corner cases plus random divide/sqrt traffic.
module tb_fdivsqrt_iter;

`ifdef FDIVSQRT_RADIX4_EN
  localparam int LAT = 14;
`else
  localparam int LAT = 27;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, start, is_divide, sqrt_shift;
  logic [23:0] lhs_mant, rhs_mant;
  logic        ready, busy, done;
  logic [25:0] quo;
  logic [26:0] rem;

  fdivsqrt_iter dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .is_divide(is_divide),
    .lhs_mant(lhs_mant), .rhs_mant(rhs_mant), .sqrt_shift(sqrt_shift),
    .ready(ready), .busy(busy), .done(done), .quo(quo), .rem(rem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [25:0] q;
    logic [26:0] r;
    int          c;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic straight from the floor/remainder equations
  function automatic void ref_model(input logic d, input logic [23:0] a, input logic [23:0] b,
                                    input logic sh, output logic [25:0] q, output logic [26:0] r);
    longint num, qq, rr, x;
    if (d) begin
      num = longint'(a) << 25;
      qq  = num / longint'(b);
      rr  = num - qq * longint'(b);
    end else begin
      x   = longint'(a) << sh;
      num = x << 27;
      qq  = longint'($floor($sqrt(real'(num))));
      while (qq * qq > num) qq--;
      while ((qq + 1) * (qq + 1) <= num) qq++;
      rr  = num - qq * qq;
    end
    q = qq[25:0];
    r = rr[26:0];
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 with empty scoreboard, quo=0x%0h rem=0x%0h (cycle %0d)",
                 quo, rem, cyc);
      end else begin
        e = sb.pop_front();
        chk("quo", {38'd0, quo}, {38'd0, e.q});
        chk("rem", {37'd0, rem}, {37'd0, e.r});
        chk("done_cycle", 64'(cyc), 64'(e.c));
      end
    end
  end

  task automatic issue(input logic d, input logic [23:0] a, input logic [23:0] b, input logic sh,
                       input bit push, input bit given, input logic [25:0] gq, input logic [26:0] gr);
    int          n = 0;
    exp_t        e;
    logic [25:0] mq;
    logic [26:0] mr;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    if (!ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: ready=%0b, expected 1 within 200 cycles", ready);
    end
    is_divide  = d;
    lhs_mant   = a;
    rhs_mant   = b;
    sqrt_shift = sh;
    start      = 1'b1;
    if (push) begin
      ref_model(d, a, b, sh, mq, mr);
      e.q = given ? gq : mq;
      e.r = given ? gr : mr;
      e.c = cyc + LAT;
      sb.push_back(e);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !ready) && n < 400) begin
      tick();
      n++;
    end
    if (sb.size() != 0 || !ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: pending=%0d ready=%0b, expected 0 and 1", sb.size(), ready);
    end
  endtask

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; start = 1'b0; is_divide = 1'b0; sqrt_shift = 1'b0;
    lhs_mant = '0; rhs_mant = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_busy",  64'(busy),  64'd0);
    chk("reset_done",  64'(done),  64'd0);
    chk("reset_quo",   64'(quo),   64'd0);
    chk("reset_rem",   64'(rem),   64'd0);

    // 1.0 / 1.0
    issue(1'b1, 24'h800000, 24'h800000, 1'b0, 1'b1, 1'b1, 26'h2000000, 27'h0);
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("ready_after_start", 64'(ready), 64'd0);
    wait_idle();

    // 1.0 / 1.5, reissued in the DONE cycle
    issue(1'b1, 24'h800000, 24'hC00000, 1'b0, 1'b1, 1'b1, 26'h1555555, 27'h400000);
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    chk("done_seen_for_b2b", 64'(done), 64'd1);
    issue(1'b1, 24'h800000, 24'hC00000, 1'b0, 1'b1, 1'b1, 26'h1555555, 27'h400000);
    wait_idle();

    // sqrt 1.0 and 2.25
    issue(1'b0, 24'h800000, 24'h0, 1'b0, 1'b1, 1'b1, 26'h2000000, 27'h0);
    issue(1'b0, 24'h900000, 24'h0, 1'b1, 1'b1, 1'b1, 26'h3000000, 27'h0);
    wait_idle();

    // flush at T+10, new start at T+12
    issue(1'b1, 24'hABCDEF, 24'h812345, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy",  64'(busy),  64'd0);
    chk("flush_ready", 64'(ready), 64'd1);
    issue(1'b1, 24'hFFFFFF, 24'h800001, 1'b0, 1'b1, 1'b0, '0, '0);
    wait_idle();

    // flush together with start from idle: start dropped
    tick();
    flush = 1'b1; start = 1'b1; is_divide = 1'b1; lhs_mant = 24'h900000; rhs_mant = 24'h800000;
    tick();
    flush = 1'b0; start = 1'b0;
    chk("flush_start_busy", 64'(busy), 64'd0);
    tick();

    // start pulsed at T+5 while busy is ignored, operands not relatched
    issue(1'b0, 24'hC34567, 24'h0, 1'b0, 1'b1, 1'b0, '0, '0);
    repeat (4) tick();
    chk("busy_ready_low", 64'(ready), 64'd0);
    start = 1'b1; is_divide = 1'b1; lhs_mant = 24'hFFFFFF; rhs_mant = 24'h800000; sqrt_shift = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();

    // reset mid-ITER
    issue(1'b1, 24'hDEAD01, 24'hBEEF01, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_busy",  64'(busy),  64'd0);
    chk("midrst_done",  64'(done),  64'd0);
    chk("midrst_quo",   64'(quo),   64'd0);
    chk("midrst_rem",   64'(rem),   64'd0);
    rst = 1'b0;
    repeat (LAT + 2) tick();

    // random traffic, mostly back-to-back
    for (int i = 0; i < 2500; i++) begin
      logic        d, sh;
      logic [23:0] a, b;
      d  = 1'($urandom_range(0, 1));
      sh = 1'($urandom_range(0, 1));
      a  = 24'h800000 | 24'($urandom() & 32'h7FFFFF);
      b  = 24'h800000 | 24'($urandom() & 32'h7FFFFF);
      case ($urandom_range(0, 15))
        0: a = 24'hFFFFFF;
        1: b = 24'hFFFFFF;
        2: b = a;
        3: a = 24'h800000;
        default: ;
      endcase
      issue(d, a, b, sh, 1'b1, 1'b0, '0, '0);
      if ($urandom_range(0, 7) == 0) begin
        wait_idle();
        tick();
      end
    end
    wait_idle();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
